mdu_hilo: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers, directly downstream of the register file.
- Consumes the two register-file read ports (RDA as operand A/rs, RDB as operand B/rt).
- Services MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO to the write-back mux for MFHI/MFLO, and a busy flag the control path uses to stall the PC.

---
 rtl/mdu_hilo.sv | 85 ++++++++
 tb/tb_mdu_hilo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m, mag_a, mag_b, q, r;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH:0] sum, t, d;
  logic div, neg, sgn_a;
  // operand magnitudes for signed ops, one-bit iteration step and sign fix-up
  always_comb begin
    mag_a = (!op[0] && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b = (!op[0] && op_b[WIDTH-1]) ? -op_b : op_b;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : {WIDTH{1'b0}}};
    t = acc[2*WIDTH-1:WIDTH-1];
    d = t - {1'b0, m};
    acc_nx = !div ? {sum, acc[WIDTH-1:1]} :
             d[WIDTH] ? {t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
             {d[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod = neg ? -acc : acc;
    q = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r = sgn_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  // control FSM: accept in IDLE, iterate WIDTH cycles, then correct signs and commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      m <= '0;
      acc <= '0;
      div <= 1'b0;
      neg <= 1'b0;
      sgn_a <= 1'b0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (op == 3'b100) hi <= op_a;
          else if (op == 3'b101) lo <= op_a;
          else if (!op[2]) begin
            m <= op[1] ? mag_b : mag_a;
            acc <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            div <= op[1];
            neg <= !op[0] && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            sgn_a <= !op[0] && op_a[WIDTH-1];
            cnt <= '0;
            busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          hi <= div ? r : prod[2*WIDTH-1:WIDTH];
          lo <= !div ? prod[WIDTH-1:0] : (m == '0) ? {WIDTH{1'b1}} : q;
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard-driven directed bench for the HI/LO multiply/divide unit
module tb_mdu_hilo;
  logic clk = 0, rst = 0, start = 0;
  logic [2:0] op = 0;
  logic [31:0] op_a = 0, op_b = 0, hi, lo;
  logic busy, done;
  int checks = 0, errors = 0;
  logic [63:0] sb[$];

  mdu_hilo dut (.clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
                .hi(hi), .lo(lo), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b);
    longint p;
    int qq, rr;
    case (o)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qq = $signed(a) / $signed(b);
        rr = $signed(a) % $signed(b);
        return {rr, qq};
      end
      3'd3: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return 64'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [2:0] o, input logic [31:0] a, b);
    @(negedge clk);
    start = 1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 0; op_a = $urandom; op_b = $urandom;
  endtask

  task automatic collect(input string tag, input int pulse_at);
    int n = 0;
    logic held = 1;
    logic [63:0] old = {hi, lo};
    logic [63:0] exp;
    while (busy && n < 40) begin
      held &= ({hi, lo} === old);
      start = (n == pulse_at);
      if (n == pulse_at) begin op = 3'b100; op_a = 32'hDEAD; end
      n++;
      @(negedge clk);
    end
    start = 0;
    chk({tag, "_busy_len"}, 64'(n), 64'd33);
    chk({tag, "_hold"}, 64'(held), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd1);
    exp = sb.size() ? sb.pop_front() : 64'hx;
    chk({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    #12;
    chk("rst_vals", {hi, lo, 30'b0, busy, done}, 96'h0);
    @(negedge clk); rst = 1;
    go(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    #2 rst = 0;
    #1 chk("rst_mid_run", {hi, lo, 30'b0, busy, done}, 96'h0);
    @(negedge clk); rst = 1;
    go(3'b101, 32'h1234, 32'h0);
    chk("mtlo_after_rst", {lo, 31'b0, busy}, {32'h1234, 32'h0});

    sb.push_back({32'hFFFF_FFFE, 32'h1});
    go(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("multu", -1);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);

    sb.push_back({32'h0, 32'h1});
    go(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("mult", -1);

    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    go(3'd2, 32'hFFFF_FFF9, 32'd2);
    collect("div", -1);

    sb.push_back({32'h1, 32'h7FFF_FFFC});
    go(3'd3, 32'hFFFF_FFF9, 32'd2);
    collect("divu", -1);

    sb.push_back({32'h55, 32'hFFFF_FFFF});
    go(3'd3, 32'h55, 32'h0);
    collect("divu_by0", -1);

    sb.push_back({32'hFFFF_FFFB, 32'hFFFF_FFFF});
    go(3'd2, 32'hFFFF_FFFB, 32'h0);
    collect("div_by0", -1);

    sb.push_back({32'h0, 32'h8000_0000});
    go(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    collect("div_ovf", -1);

    sb.push_back(model(3'd0, 32'd3, 32'hFFFF_FFFC));
    go(3'd0, 32'd3, 32'hFFFF_FFFC);
    collect("start_busy", 9);
    chk("start_busy_nodead", 64'(hi == 32'hDEAD), 64'd0);

    sb.push_back(model(3'd3, 32'd100, 32'd7));
    go(3'd3, 32'd100, 32'd7);
    collect("b2b_first", -1);
    start = 1; op = 3'd3; op_a = 32'd1000; op_b = 32'd3;
    sb.push_back(model(3'd3, 32'd1000, 32'd3));
    @(negedge clk);
    start = 0;
    chk("b2b_busy", 64'(busy), 64'd1);
    collect("b2b_second", -1);

    go(3'b100, 32'hCAFE, 32'h0);
    chk("mthi_idle", {hi, 30'b0, busy, done}, {32'hCAFE, 32'h0});

    go(3'b110, 32'h1111, 32'h2222);
    chk("reserved", {hi, 31'b0, busy}, {32'hCAFE, 32'h0});

    for (int i = 0; i < 8; i++) begin
      logic [2:0] o = 3'(i % 4);
      logic [31:0] a = (i == 4) ? 32'h8000_0000 : $urandom;
      logic [31:0] b = (i == 5) ? 32'h8000_0000 : (i == 6) ? 32'h0 : $urandom;
      if (i == 7) b = $urandom_range(1, 15);
      sb.push_back(model(o, a, b));
      go(o, a, b);
      collect("rand", -1);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
